// File: rtl/chess_turn_ctrl.sv
// Turn controller for a two-player chess clock: selects the running timer,
// counts moves, pauses on request and latches the player whose flag fell.
module chess_turn_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       SELECT,
  input  logic       STOP,
  input  logic       Set_Impulse,
  input  logic       ZERO_A,
  input  logic       ZERO_B,
  output logic       CE_A,
  output logic       CE_B,
  output logic       LOAD,
  output logic       ACTIVE,
  output logic [2:0] STATE,
  output logic       TIMEOUT,
  output logic       LOSER,
  output logic [7:0] MOVES
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READY   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  logic [2:0] state;
  logic       active;
  logic       load_q;
  logic       loser_q;
  logic [7:0] moves;
  logic       sel_q;
  logic       set_q;

  logic sel_edge;
  logic set_edge;
  logic new_game;
  logic flag_fell;

  assign sel_edge  = SELECT & ~sel_q;
  assign set_edge  = Set_Impulse & ~set_q;
  // A new game may be loaded from any state except while the clock is running.
  assign new_game  = set_edge & (state != S_RUN);
  assign flag_fell = active ? ZERO_B : ZERO_A;

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state   <= S_IDLE;
      active  <= FIRST_PLAYER;
      moves   <= 8'd0;
      load_q  <= 1'b0;
      loser_q <= 1'b0;
      sel_q   <= 1'b1;
      set_q   <= 1'b1;
    end else begin
      sel_q  <= SELECT;
      set_q  <= Set_Impulse;
      load_q <= 1'b0;
      if (new_game) begin
        load_q  <= 1'b1;
        active  <= FIRST_PLAYER;
        moves   <= 8'd0;
        loser_q <= 1'b0;
        state   <= S_READY;
      end else begin
        case (state)
          S_READY: begin
            if (sel_edge && !STOP) state <= S_RUN;
          end
          S_RUN: begin
            if (flag_fell) begin
              state   <= S_TIMEOUT;
              loser_q <= active;
            end else if (STOP) begin
              state <= S_PAUSE;
            end else if (sel_edge) begin
              active <= ~active;
              if (moves != 8'hFF) moves <= moves + 8'd1;
            end
          end
          S_PAUSE: begin
            if (!STOP) state <= S_RUN;
          end
          S_IDLE, S_TIMEOUT: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign CE_A    = (state == S_RUN) & CE & ~active & ~STOP;
  assign CE_B    = (state == S_RUN) & CE &  active & ~STOP;
  assign LOAD    = load_q;
  assign ACTIVE  = active;
  assign STATE   = state;
  assign TIMEOUT = (state == S_TIMEOUT);
  assign LOSER   = loser_q;
  assign MOVES   = moves;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Self-checking bench for chess_turn_ctrl: directed vector table, hand-written
// reset/saturation sequences, then random play against a game-level model.
module tb_chess_turn_ctrl;

   localparam int ST_IDLE    = 0;
   localparam int ST_READY   = 1;
   localparam int ST_RUN     = 2;
   localparam int ST_PAUSE   = 3;
   localparam int ST_TIMEOUT = 4;

   logic clk = 1'b0;
   logic clr, ce, sel, stop, setImp, zeroA, zeroB;
   logic ceA, ceB, load, active, timeout, loser;
   logic [2:0] state;
   logic [7:0] moves;
   logic bCeA, bCeB, bLoad, bActive, bTimeout, bLoser;
   logic [2:0] bState;
   logic [7:0] bMoves;

   int errors = 0;
   int checks = 0;

   // Game-level reference model
   int   mState = ST_IDLE;
   bit   mActive = 1'b0;
   int   mMoves = 0;
   bit   mLoad = 1'b0;
   bit   mLoser = 1'b0;
   bit   mSelPrev = 1'b1;
   bit   mSetPrev = 1'b1;
   bit   mCeA, mCeB;
   logic gotCeA, gotCeB;

   typedef struct {
      logic       clr, ce, sel, stop, setImp, zeroA, zeroB;
      logic [2:0] expState;
      logic       expActive;
      logic [7:0] expMoves;
      logic       expLoad, expTimeout, expLoser, expCeA, expCeB;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   chess_turn_ctrl dut (
      .CLK(clk), .CLR(clr), .CE(ce), .SELECT(sel), .STOP(stop),
      .Set_Impulse(setImp), .ZERO_A(zeroA), .ZERO_B(zeroB),
      .CE_A(ceA), .CE_B(ceB), .LOAD(load), .ACTIVE(active), .STATE(state),
      .TIMEOUT(timeout), .LOSER(loser), .MOVES(moves)
   );

   chess_turn_ctrl #(.FIRST_PLAYER(1'b1)) dutB (
      .CLK(clk), .CLR(clr), .CE(ce), .SELECT(sel), .STOP(stop),
      .Set_Impulse(setImp), .ZERO_A(zeroA), .ZERO_B(zeroB),
      .CE_A(bCeA), .CE_B(bCeB), .LOAD(bLoad), .ACTIVE(bActive), .STATE(bState),
      .TIMEOUT(bTimeout), .LOSER(bLoser), .MOVES(bMoves)
   );

   function automatic vec_t mk(input logic c, e, s, p, l, za, zb,
                               input logic [2:0] st, input logic a,
                               input logic [7:0] mv, input logic ld, to, ls, ca, cb);
      vec_t v;
      v.clr = c; v.ce = e; v.sel = s; v.stop = p; v.setImp = l;
      v.zeroA = za; v.zeroB = zb;
      v.expState = st; v.expActive = a; v.expMoves = mv; v.expLoad = ld;
      v.expTimeout = to; v.expLoser = ls; v.expCeA = ca; v.expCeB = cb;
      return v;
   endfunction

   // Advance the model by one clock edge using the game rules.
   task automatic modelStep();
      bit selRise, setRise, flagDown;
      selRise = sel && !mSelPrev;
      setRise = setImp && !mSetPrev;
      mLoad = 1'b0;
      if (!clr) begin
         mState = ST_IDLE; mActive = 1'b0; mMoves = 0; mLoser = 1'b0;
         mSelPrev = 1'b1; mSetPrev = 1'b1;
         return;
      end
      mSelPrev = sel;
      mSetPrev = setImp;
      if (setRise && mState != ST_RUN) begin
         mLoad = 1'b1; mActive = 1'b0; mMoves = 0; mLoser = 1'b0;
         mState = ST_READY;
         return;
      end
      if (mState == ST_READY) begin
         if (selRise && !stop) mState = ST_RUN;
      end else if (mState == ST_RUN) begin
         flagDown = (mActive == 1'b0) ? zeroA : zeroB;
         if (flagDown) begin
            mState = ST_TIMEOUT;
            mLoser = mActive;
         end else if (stop) begin
            mState = ST_PAUSE;
         end else if (selRise) begin
            mActive = !mActive;
            mMoves = (mMoves >= 255) ? 255 : mMoves + 1;
         end
      end else if (mState == ST_PAUSE) begin
         if (!stop) mState = ST_RUN;
      end
   endtask

   // Drive one cycle of inputs, capture the combinational enables mid-cycle,
   // then let the edge happen and update the model.
   task automatic applyStimulus(input logic c, e, s, p, l, za, zb);
      @(negedge clk);
      clr = c; ce = e; sel = s; stop = p; setImp = l; zeroA = za; zeroB = zb;
      #1;
      gotCeA = ceA;
      gotCeB = ceB;
      mCeA = (mState == ST_RUN) && e && !mActive && !p;
      mCeB = (mState == ST_RUN) && e && mActive && !p;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic checkRegs(input string tag, input logic [2:0] st, input logic a,
                            input logic [7:0] mv, input logic ld, to, ls);
      checkOutput({tag, " STATE"}, {5'd0, state}, {5'd0, st});
      checkOutput({tag, " ACTIVE"}, {7'd0, active}, {7'd0, a});
      checkOutput({tag, " MOVES"}, moves, mv);
      checkOutput({tag, " LOAD"}, {7'd0, load}, {7'd0, ld});
      checkOutput({tag, " TIMEOUT"}, {7'd0, timeout}, {7'd0, to});
      checkOutput({tag, " LOSER"}, {7'd0, loser}, {7'd0, ls});
   endtask

   task automatic checkAgainstModel(input string tag);
      checkOutput({tag, " CE_A"}, {7'd0, gotCeA}, {7'd0, mCeA});
      checkOutput({tag, " CE_B"}, {7'd0, gotCeB}, {7'd0, mCeB});
      checkRegs(tag, mState[2:0], mActive, mMoves[7:0], mLoad,
                mState == ST_TIMEOUT, mLoser);
   endtask

   initial begin
      string tag;
      clr = 1'b0; ce = 1'b0; sel = 1'b0; stop = 1'b0; setImp = 1'b0;
      zeroA = 1'b0; zeroB = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      //            clr ce sel stp set za zb  st a mv ld to ls ca cb
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 4, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 4, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0, 4, 0, 4, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4, 0, 4, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1, 4, 1, 1, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].clr, vecs[i].ce, vecs[i].sel, vecs[i].stop,
                       vecs[i].setImp, vecs[i].zeroA, vecs[i].zeroB);
         tag = $sformatf("row%0d", i);
         checkOutput({tag, " CE_A"}, {7'd0, gotCeA}, {7'd0, vecs[i].expCeA});
         checkOutput({tag, " CE_B"}, {7'd0, gotCeB}, {7'd0, vecs[i].expCeB});
         checkRegs(tag, vecs[i].expState, vecs[i].expActive, vecs[i].expMoves,
                   vecs[i].expLoad, vecs[i].expTimeout, vecs[i].expLoser);
         if (i == 0 || i == 2)
            checkOutput({tag, " FP1 ACTIVE"}, {7'd0, bActive}, 8'd1);
         if (i == 7)
            checkOutput({tag, " FP1 ACTIVE"}, {7'd0, bActive}, 8'd0);
      end

      // Reset in the middle of a game with both buttons held down.
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkRegs("midrun enter", 3'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkRegs("midrun toggle", 3'd2, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1, 1, 0, 1, 0, 0);
      checkRegs("clr held", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1, 1, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 1, 0, 0);
      checkOutput("post-clr CE_A", {7'd0, gotCeA}, 8'd0);
      checkRegs("post-clr held", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkRegs("set released", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 1, 0, 1, 0, 0);
      checkRegs("set re-press", 3'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkRegs("sel still held", 3'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      checkRegs("sel re-press", 3'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Move counter saturation.
      for (int n = 1; n <= 260; n++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         applyStimulus(1, 0, 1, 0, 0, 0, 0);
         if (n == 254 || n == 255 || n == 260)
            checkOutput($sformatf("sat n=%0d MOVES", n), moves, (n > 255) ? 8'd255 : 8'(n));
      end

      // Random play against the model.
      for (int k = 0; k < 3000; k++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 9) < 7,
                       $urandom_range(0, 9) < 4,
                       $urandom_range(0, 99) < 12,
                       $urandom_range(0, 99) < 5,
                       $urandom_range(0, 99) < 3,
                       $urandom_range(0, 99) < 3);
         checkAgainstModel($sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/chess_turn_ctrl.md
CHESS_TURN_CTRL -- requirements
Module: chess_turn_ctrl

Interface
REQ-001 The block SHALL have one parameter: FIRST_PLAYER, default 0, player whose clock runs first after a load (0=A, 1=B).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be as listed below.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 CLR  in  1  synchronous active-low reset.
REQ-005 CE  in  1  one-cycle time-base tick from the prescaler.
REQ-006 SELECT  in  1  turn-change button, level; only rising edges act.
REQ-007 STOP  in  1  pause request, level.
REQ-008 Set_Impulse  in  1  load/new-game button, level; only rising edges act.
REQ-009 ZERO_A, ZERO_B  in  1 each  player A/B timer at 00:00.
REQ-010 CE_A, CE_B  out  1 each  count enables to the A/B down-timers.
REQ-011 LOAD  out  1  one-cycle strobe loading preset time into both timers.
REQ-012 ACTIVE  out  1  player on move (0=A, 1=B).
REQ-013 STATE  out  3  IDLE=0, READY=1, RUN=2, PAUSE=3, TIMEOUT=4.
REQ-014 TIMEOUT  out  1  high while in TIMEOUT.
REQ-015 LOSER  out  1  player whose flag fell; valid while TIMEOUT=1.
REQ-016 MOVES  out  8  count of turn changes since the last load.

Function
REQ-017 Edge detect: each of SELECT and Set_Impulse SHALL be registered once; edge = input & ~registered input.
REQ-018 An edge sampled at clock edge k SHALL take effect on STATE, ACTIVE, MOVES and LOAD at that same edge k, with outputs visible in the following cycle.
REQ-019 IDLE: on a Set_Impulse edge, LOAD=1 for one cycle, ACTIVE=FIRST_PLAYER, MOVES=0, go to READY; all other inputs SHALL be ignored.
REQ-020 READY: on a SELECT edge with STOP=0, go to RUN; ACTIVE unchanged; MOVES unchanged.
REQ-021 READY: a Set_Impulse edge SHALL re-issue LOAD and stay in READY.
REQ-022 RUN: CE_A = CE & ~ACTIVE & ~STOP and CE_B = CE & ACTIVE & ~STOP, combinationally; in every other state CE_A=CE_B=0.
REQ-023 RUN: a SELECT edge SHALL toggle ACTIVE and increment MOVES, saturating at 255.
REQ-024 RUN: STOP=1 SHALL move to PAUSE; CE gating SHALL already be 0 in the cycle in which STOP is sampled high.
REQ-025 RUN: ZERO of the active player SHALL move to TIMEOUT with LOSER=ACTIVE; ZERO of the inactive player SHALL be ignored.
REQ-026 RUN priority: active-player ZERO > STOP > SELECT edge; Set_Impulse edges SHALL be ignored in RUN.
REQ-027 PAUSE: STOP=0 SHALL return to RUN with ACTIVE unchanged; SELECT edges SHALL be ignored.
REQ-028 PAUSE: a Set_Impulse edge SHALL issue LOAD, clear MOVES, set ACTIVE=FIRST_PLAYER and go to READY; this SHALL take priority over STOP=0.
REQ-029 TIMEOUT: TIMEOUT=1 and LOSER held; only a Set_Impulse edge acts, with the same effect as in REQ-028.
REQ-030 LOAD SHALL never be asserted for more than one consecutive cycle per Set_Impulse edge.

Reset
REQ-031 With CLR=0 at a rising CLK edge: STATE=IDLE, ACTIVE=FIRST_PLAYER, MOVES=0, LOAD=0, TIMEOUT=0, LOSER=0, CE_A=CE_B=0; this SHALL take priority over all other inputs in any state.
REQ-032 With CLR=0, both edge-detect registers SHALL be set to 1, so a button held through reset SHALL produce no edge.
REQ-033 Reset SHALL NOT require CE activity; the block SHALL operate on the first edge after CLR returns to 1.

Verification
REQ-034 Reset, then a Set_Impulse pulse, then a SELECT pulse -> LOAD high for exactly 1 cycle; STATE 0->1->2; ACTIVE=0; CE_A mirrors CE; CE_B=0.
REQ-035 In RUN, 3 SELECT pulses -> ACTIVE toggles 0->1->0->1; MOVES=3; CE tracks ACTIVE with no tick lost or duplicated at the switch.
REQ-036 In RUN with ACTIVE=1, STOP=1 for 10 cycles with CE every cycle, while SELECT is pulsed -> STATE=3; CE_A=CE_B=0; ACTIVE and MOVES unchanged; STOP=0 -> STATE=2.
REQ-037 In RUN with ACTIVE=0: ZERO_B=1 -> no effect; ZERO_A=1 in the same cycle as a SELECT edge -> STATE=4, LOSER=0, MOVES unchanged, CE gated off.
REQ-038 From TIMEOUT, a Set_Impulse pulse -> LOAD 1 cycle, STATE=1, MOVES=0, TIMEOUT=0.
REQ-039 CLR=0 asserted mid-RUN with SELECT held high, then released -> all outputs at reset values; no edge recognised until SELECT falls and rises again.
